vga_timing: RTL and testbench

Free-running 800x600 @ 60 Hz (40 MHz pixel clock) VGA timing generator at the head of the video pipeline. It produces the horizontal/vertical pixel counters, sync pulses and blanking flags that the background-drawing stage consumes one stage downstream. All outputs are registered and mutually cycle-aligned, so downstream stages only need to add their own fixed latency.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_axis_cnt.sv | 71 +++++++
 rtl/vga_timing.sv | 92 +++++++++
 tb/tb_vga_timing.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 800x600 @ 60 Hz constants and the
// counter width used by the timing generator and the drawing stages.
package vga_pkg;

  // Width of the pixel/line counters (covers totals up to 2048).
  localparam int VGA_CNT_W = 11;

  // Default horizontal timing, in pixels.
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;

  // Default vertical timing, in lines.
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;

  // Total period of one axis (active + porches + sync).
  function automatic int vga_axis_total(input int active, input int fp,
                                        input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int VGA_H_TOTAL = vga_axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL = vga_axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_cnt.sv
// One axis of the VGA raster: a wrapping position counter plus registered
// blank/sync decode. The flags are decoded from the next count so they are
// aligned with the count they are presented alongside.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter int W      = VGA_CNT_W
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_blank,
  output logic         o_sync,
  output logic         o_wrap
);

  localparam int TOTAL = vga_axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] C_ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] C_SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] C_SYNC_END   = W'(ACTIVE + FP + SYNC);

  // The unsigned counter must be able to hold every position of the axis.
  generate
    if (TOTAL > (2 ** W) || TOTAL < 2) begin : g_bad_total
      $error("vga_axis_cnt: axis total %0d does not fit a %0d-bit counter", TOTAL, W);
    end
  endgenerate

  logic [W-1:0] r_count;
  logic         r_blank;
  logic         r_sync;
  logic [W-1:0] w_count_next;
  logic         w_last;

  assign w_last = (r_count == C_LAST);
  // Wrap is combinational so the next axis can advance on the same edge.
  assign o_wrap = i_en & w_last;

  // Next position: advance when enabled, wrapping at the end of the axis.
  always_comb begin
    w_count_next = r_count;
    if (i_en) begin
      w_count_next = w_last ? '0 : r_count + 1'b1;
    end
  end

  // Register the count and the flags decoded from the next count.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_count <= '0;
      r_blank <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_blank <= (w_count_next >= C_ACT_END);
      r_sync  <= (w_count_next >= C_SYNC_START) && (w_count_next < C_SYNC_END);
    end
  end

  assign o_count = r_count;
  assign o_blank = r_blank;
  assign o_sync  = r_sync;

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA timing generator (default 800x600 @ 60 Hz, 40 MHz pclk).
// All outputs are registered and mutually aligned.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds sof and frame_cnt.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic                 pclk,
  input  logic                 rst,
  output logic [VGA_CNT_W-1:0] hcount,
  output logic [VGA_CNT_W-1:0] vcount,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 hblnk,
  output logic                 vblnk
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic                 sof,
  output logic [15:0]          frame_cnt
`endif
);

  logic w_h_wrap;
  logic w_v_wrap;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (VGA_CNT_W)
  ) u_h_axis (
    .i_clk   (pclk),
    .i_srst  (rst),
    .i_en    (1'b1),
    .o_count (hcount),
    .o_blank (hblnk),
    .o_sync  (hsync),
    .o_wrap  (w_h_wrap)
  );

  // The vertical axis advances once per completed line.
  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (VGA_CNT_W)
  ) u_v_axis (
    .i_clk   (pclk),
    .i_srst  (rst),
    .i_en    (w_h_wrap),
    .o_count (vcount),
    .o_blank (vblnk),
    .o_sync  (vsync),
    .o_wrap  (w_v_wrap)
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        r_sof;
  logic [15:0] r_frame_cnt;

  // Both axes wrapping means the next output is position 0,0: flag it and
  // count the frame on the same edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_sof       <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_sof <= w_v_wrap;
      if (w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign sof       = r_sof;
  assign frame_cnt = r_frame_cnt;
`else
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: one instance with the default 800x600
// timing and one with a tiny raster (16x12) so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing;

  logic        pclk;
  logic        rst;

  logic [10:0] b_hcount, b_vcount;
  logic        b_hsync, b_vsync, b_hblnk, b_vblnk;
  logic [10:0] s_hcount, s_vcount;
  logic        s_hsync, s_vsync, s_hblnk, s_vblnk;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        b_sof, s_sof;
  logic [15:0] b_frame_cnt, s_frame_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pos_b;
  int pos_s;
  int hs_width;

  vga_timing u_big (
    .pclk      (pclk),
    .rst       (rst),
    .hcount    (b_hcount),
    .vcount    (b_vcount),
    .hsync     (b_hsync),
    .vsync     (b_vsync),
    .hblnk     (b_hblnk),
    .vblnk     (b_vblnk)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .sof       (b_sof),
    .frame_cnt (b_frame_cnt)
`endif
  );

  // Small raster: H 8+2+3+3=16, V 6+1+2+3=12, frame = 192 cycles.
  vga_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (3)
  ) u_small (
    .pclk      (pclk),
    .rst       (rst),
    .hcount    (s_hcount),
    .vcount    (s_vcount),
    .hsync     (s_hsync),
    .vsync     (s_vsync),
    .hblnk     (s_hblnk),
    .vblnk     (s_vblnk)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .sof       (s_sof),
    .frame_cnt (s_frame_cnt)
`endif
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d (big pos %0d, small pos %0d)",
               tag, obs, exp, pos_b, pos_s);
    end
  endtask

  // Expected outputs for both instances given their positions (cycles since
  // reset release; 0 means in reset or the reset state).
  task automatic check_all(input int pb, input int ps);
    int bh, bv, sh, sv;
    bh = pb % 1056;
    bv = (pb / 1056) % 628;
    chk("big_hcount", 32'(b_hcount), 32'(bh));
    chk("big_vcount", 32'(b_vcount), 32'(bv));
    chk("big_hblnk",  32'(b_hblnk),  (bh >= 800) ? 1 : 0);
    chk("big_hsync",  32'(b_hsync),  (bh >= 840 && bh < 968) ? 1 : 0);
    chk("big_vblnk",  32'(b_vblnk),  (bv >= 600) ? 1 : 0);
    chk("big_vsync",  32'(b_vsync),  (bv >= 601 && bv < 605) ? 1 : 0);
    sh = ps % 16;
    sv = (ps / 16) % 12;
    chk("small_hcount", 32'(s_hcount), 32'(sh));
    chk("small_vcount", 32'(s_vcount), 32'(sv));
    chk("small_hblnk",  32'(s_hblnk),  (sh >= 8) ? 1 : 0);
    chk("small_hsync",  32'(s_hsync),  (sh >= 10 && sh < 13) ? 1 : 0);
    chk("small_vblnk",  32'(s_vblnk),  (sv >= 6) ? 1 : 0);
    chk("small_vsync",  32'(s_vsync),  (sv >= 7 && sv < 9) ? 1 : 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("big_sof",         32'(b_sof),       0);
    chk("big_frame_cnt",   32'(b_frame_cnt), 0);
    chk("small_sof",       32'(s_sof),       (ps > 0 && ps % 192 == 0) ? 1 : 0);
    chk("small_frame_cnt", 32'(s_frame_cnt), 32'(ps / 192));
`endif
  endtask

  task automatic step_and_check();
    @(negedge pclk);
    pos_b++;
    pos_s++;
    check_all(pos_b, pos_s);
  endtask

  initial begin
    rst   = 1'b1;
    pos_b = 0;
    pos_s = 0;

    // Reset held 5 cycles: everything at position 0,0 with flags low.
    repeat (5) begin
      @(negedge pclk);
      check_all(0, 0);
    end
    $display("reset: 5 cycles checked");

    // Two full lines and beyond; the small raster covers many frames.
    rst = 1'b0;
    hs_width = 0;
    for (int n = 1; n <= 2200; n++) begin
      step_and_check();
      if (pos_b < 1056 && b_hsync) hs_width++;
    end
    chk("big_hsync_width", 32'(hs_width), 128);
    $display("run: %0d cycles checked, line0 hsync width %0d", pos_b, hs_width);

    // Mid-line reset: next edge forces 0,0 with no partial-line completion.
    while ((pos_b % 1056) != 500) step_and_check();
    rst = 1'b1;
    @(negedge pclk);
    pos_b = 0;
    pos_s = 0;
    check_all(0, 0);
    $display("mid-line reset: outputs at 0,0");
    rst = 1'b0;
    for (int n = 1; n <= 300; n++) step_and_check();
    $display("restart: %0d cycles checked", pos_b);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame-counter wrap: preload 65535 just before a frame start.
    while ((pos_s % 192) != 190) step_and_check();
    force u_small.r_frame_cnt = 16'hFFFF;
    #1;
    release u_small.r_frame_cnt;
    for (int n = 0; n < 2; n++) begin
      @(negedge pclk);
      pos_b++;
      pos_s++;
    end
    chk("small_sof_at_wrap",       32'(s_sof),       1);
    chk("small_frame_cnt_wrapped", 32'(s_frame_cnt), 0);
    $display("frame_cnt wrap: sof=%0d frame_cnt=%0d", s_sof, s_frame_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
